// File: rtl/qsn_merge_pipe.sv
// qsn_merge_pipe: QSN merge stage (left/right shift paths -> one row) behind a valid/ready skid buffer with a saturating merge count.
module qsn_merge_pipe #(
  parameter int PC    = 5,
  parameter int QUAN  = 4,
  parameter int CNT_W = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(PC-1)*QUAN-1:0] left_in,
  input  logic [PC*QUAN-1:0]     right_in,
  input  logic [PC-2:0]          sel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC*QUAN-1:0]     sw_out,
  output logic [CNT_W-1:0]       merge_cnt
);
  logic [PC*QUAN-1:0] w_merged;
  logic [PC*QUAN-1:0] r_m;
  logic [PC*QUAN-1:0] r_s;
  logic               r_m_valid;
  logic               r_s_valid;
  logic [CNT_W-1:0]   r_cnt;
  logic               w_acc;
  logic               w_fire;
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < PC-1; i++)
      w_merged[i*QUAN +: QUAN] = sel[i] ? left_in[i*QUAN +: QUAN] : right_in[(PC-1-i)*QUAN +: QUAN];
    w_merged[(PC-1)*QUAN +: QUAN] = right_in[QUAN-1:0];
  end
  assign in_ready  = !r_s_valid;
  assign out_valid = r_m_valid;
  assign sw_out    = r_m;
  assign merge_cnt = r_cnt;
  assign w_acc     = in_valid && in_ready;
  assign w_fire    = r_m_valid && out_ready;
  // M refills whenever it is empty or draining; the skid slot only catches a row accepted during a stall.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_m       <= '0;
      r_s       <= '0;
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (!r_m_valid || w_fire) begin
        if (r_s_valid) begin
          r_m       <= r_s;
          r_s_valid <= 1'b0;
        end else if (w_acc) begin
          r_m       <= w_merged;
          r_m_valid <= 1'b1;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_acc) begin
        r_s       <= w_merged;
        r_s_valid <= 1'b1;
      end
      if (w_fire && r_cnt != {CNT_W{1'b1}})
        r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_qsn_merge_pipe.sv
// tb_qsn_merge_pipe: queue-model bench for qsn_merge_pipe with directed merge, stall, reset and saturation vectors.
module tb_qsn_merge_pipe;
  localparam int PC = 5, QUAN = 4, W = PC*QUAN, LW = (PC-1)*QUAN, SW = PC-1;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, in_valid = 0, out_ready = 1;
  logic [SW-1:0] sel = '0;
  logic [LW-1:0] left = '0;
  logic [W-1:0]  right = '0;
  logic          in_ready, out_valid, in_ready4, out_valid4;
  logic [W-1:0]  sw_out, sw_out4;
  logic [15:0]   cnt;
  logic [3:0]    cnt4;
  int n_cmp = 0, n_bad = 0, fires = 0;
  bit chk_en = 0;
  logic [W-1:0] q[$];
  qsn_merge_pipe #(.PC(PC), .QUAN(QUAN), .CNT_W(16)) dut (
    .sys_clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .left_in(left), .right_in(right), .sel(sel), .out_valid(out_valid),
    .out_ready(out_ready), .sw_out(sw_out), .merge_cnt(cnt));
  qsn_merge_pipe #(.PC(PC), .QUAN(QUAN), .CNT_W(4)) dut4 (
    .sys_clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .left_in(left), .right_in(right), .sel(sel), .out_valid(out_valid4),
    .out_ready(out_ready), .sw_out(sw_out4), .merge_cnt(cnt4));
  function automatic logic [W-1:0] merge_ref(logic [SW-1:0] s, logic [LW-1:0] l, logic [W-1:0] r);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < PC-1; i++)
      o[i*QUAN +: QUAN] = s[i] ? l[i*QUAN +: QUAN] : r[(PC-1-i)*QUAN +: QUAN];
    o[(PC-1)*QUAN +: QUAN] = r[QUAN-1:0];
    return o;
  endfunction
  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // Model: FIFO of rows held inside the stage (at most two), plus a count of output transfers.
  always @(negedge clk) begin
    bit f, a;
    if (chk_en) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
      chk("merge_cnt", 64'(cnt), 64'(fires > 65535 ? 65535 : fires));
      chk("merge_cnt4", 64'(cnt4), 64'(fires > 15 ? 15 : fires));
      if (q.size() > 0) chk("sw_out", 64'(sw_out), 64'(q[0]));
    end
    if (rst) begin
      q.delete();
      fires = 0;
    end else begin
      f = q.size() > 0 && out_ready;
      a = in_valid && q.size() < 2;
      if (f) begin
        void'(q.pop_front());
        fires++;
      end
      if (a) q.push_back(merge_ref(sel, left, right));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int acc_n, cyc;
    step;
    chk_en = 1;
    step;
    rst = 0;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_cnt", 64'(cnt), 64'd0);
    in_valid = 1; sel = 4'b0000; left = 16'h4321; right = 20'hEDCBA;
    step;
    in_valid = 0;
    chk("t1_sw_out", 64'(sw_out), 64'h ABCDE);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    step;
    chk("t1_cnt", 64'(cnt), 64'd1);
    in_valid = 1; sel = 4'b1111;
    step;
    chk("t2_a", 64'(sw_out), 64'h A4321);
    sel = 4'b0101;
    step;
    in_valid = 0;
    chk("t2_b", 64'(sw_out), 64'h AB3D1);
    step; step;
    out_ready = 0; in_valid = 1; sel = 4'b0000; right = 20'h12345;
    step;
    right = 20'h6789A;
    step;
    in_valid = 0;
    chk("t3_in_ready", {63'd0, in_ready}, 64'd0);
    step; step;
    chk("t3_hold", 64'(sw_out), 64'h54321);
    out_ready = 1;
    step;
    chk("t3_r2", 64'(sw_out), 64'h A9876);
    chk("t3_ready", {63'd0, in_ready}, 64'd1);
    step;
    chk("t3_empty", {63'd0, out_valid}, 64'd0);
    rst = 1;
    step;
    rst = 0;
    acc_n = 0; cyc = 0;
    while (acc_n < 100 && cyc < 3000) begin
      in_valid = 1'($urandom_range(0, 1));
      sel = SW'($urandom); left = LW'($urandom); right = W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      if (in_valid && in_ready) acc_n++;
      step;
      cyc++;
    end
    in_valid = 0; out_ready = 1;
    chk("t4_accepted", 64'(acc_n), 64'd100);
    for (int i = 0; i < 10; i++) step;
    chk("t4_cnt", 64'(cnt), 64'd100);
    chk("t4_drained", {63'd0, out_valid}, 64'd0);
    out_ready = 0; in_valid = 1; sel = 4'b0000; right = 20'h11111;
    step;
    right = 20'h22222;
    step;
    chk("t5_full", {63'd0, in_ready}, 64'd0);
    rst = 1; out_ready = 1;
    step;
    rst = 0; in_valid = 0;
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_ready", {63'd0, in_ready}, 64'd1);
    chk("t5_cnt", 64'(cnt), 64'd0);
    in_valid = 1; sel = 4'b1111; left = 16'h4321; right = 20'hEDCBA;
    step;
    in_valid = 0;
    chk("t5_row", 64'(sw_out), 64'h A4321);
    step;
    rst = 1;
    step;
    rst = 0; in_valid = 1; out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      sel = SW'($urandom); left = LW'($urandom); right = W'($urandom);
      step;
    end
    in_valid = 0;
    step; step;
    chk("t6_cnt4", 64'(cnt4), 64'd15);
    chk("t6_cnt", 64'(cnt), 64'd20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
